// File: rtl/sdram_port_arbiter.sv
// Two-port (display read / frame-buffer write) arbiter in front of a single SDRAM controller port.
// Optional grant statistics are enabled by defining ARB_STATS_EN.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              sdram_clk,
  input  logic              iRST_n,
  input  logic              done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest,
  output logic [15:0]       rd_grant_cnt,
  output logic [15:0]       wr_grant_cnt
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} state_t;

  localparam logic [2:0] LAT_INIT   = 3'(RD_LAT);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [2:0]          lat_q, lat_d;
  logic [7:0]          streak_q, streak_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_ack      = 1'b0;
    wr_ack      = 1'b0;

    case (state_q)
      IDLE: begin
        if (done) begin
          if (wr_req && (!rd_req || (streak_q >= STARVE_LIM))) begin
            state_d     = WR_ISSUE;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
          end else if (rd_req) begin
            state_d    = RD_ISSUE;
            mem_addr_d = rd_addr;
          end
        end
      end
      RD_ISSUE: begin
        rd_ack = ~mem_waitrequest;
        if (rd_ack) begin
          state_d = RD_WAIT;
          lat_d   = LAT_INIT;
        end
      end
      RD_WAIT: begin
        // Counter value 1 marks the edge on which the controller's read word is valid.
        if (lat_q == 3'd1) begin
          rd_data_d  = mem_readdata;
          rd_valid_d = 1'b1;
          lat_d      = 3'd0;
          state_d    = IDLE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      WR_ISSUE: begin
        wr_ack = ~mem_waitrequest;
        if (wr_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Consecutive reads granted while a write is pending; saturates.
    if (!wr_req || wr_ack) begin
      streak_d = 8'd0;
    end else if (rd_ack && (streak_q != 8'hFF)) begin
      streak_d = streak_q + 8'd1;
    end else begin
      streak_d = streak_q;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (!iRST_n) begin
      state_q     <= IDLE;
      lat_q       <= 3'd0;
      streak_q    <= 8'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      streak_q    <= streak_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign mem_read  = (state_q == RD_ISSUE);
  assign mem_write = (state_q == WR_ISSUE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

`ifdef ARB_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + {15'd0, rd_ack};
    wr_cnt_d = wr_cnt_q + {15'd0, wr_ack};
  end

  always_ff @(posedge sdram_clk) begin
    if (!iRST_n) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_grant_cnt = rd_cnt_q;
  assign wr_grant_cnt = wr_cnt_q;
`else
  assign rd_grant_cnt = 16'd0;
  assign wr_grant_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_sdram_port_arbiter;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  logic        sdram_clk = 1'b0;
  logic        iRST_n = 1'b0;
  logic        done = 1'b0;
  logic        rd_req = 1'b0;
  logic [24:0] rd_addr = '0;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_req = 1'b0;
  logic [24:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        mem_read;
  logic        mem_write;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_readdata = '0;
  logic        mem_waitrequest = 1'b0;
  logic [15:0] rd_grant_cnt;
  logic [15:0] wr_grant_cnt;

  int checks = 0;
  int failures = 0;

  sdram_port_arbiter #(
    .ADDR_W(25), .DATA_W(16), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .sdram_clk(sdram_clk), .iRST_n(iRST_n), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .rd_grant_cnt(rd_grant_cnt), .wr_grant_cnt(wr_grant_cnt)
  );

  always #5 sdram_clk = ~sdram_clk;

  // Reference model: which command is presented to the controller (0 none, 1 read, 2 write),
  // edges left until the outstanding read word arrives, and the expected visible results.
  int          m_cmd = 0;
  int          m_lat = 0;
  int          m_streak = 0;
  logic [24:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  bit          m_rv = 0;
  int          m_rdcnt = 0;
  int          m_wrcnt = 0;
  logic [15:0] mem_arr [8];

  always @(posedge sdram_clk) begin
    bit racc, wacc;
    int ns;
    if (!iRST_n) begin
      m_cmd = 0; m_lat = 0; m_streak = 0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_rv = 0; m_rdcnt = 0; m_wrcnt = 0;
    end else begin
      racc = (m_cmd == 1) && !mem_waitrequest;
      wacc = (m_cmd == 2) && !mem_waitrequest;
      if (!wr_req || wacc) ns = 0;
      else if (racc) ns = (m_streak < 255) ? m_streak + 1 : 255;
      else ns = m_streak;
      m_rv = 0;
      if (m_lat > 0) begin
        m_lat = m_lat - 1;
        if (m_lat == 0) begin
          m_rdata = mem_readdata;
          m_rv = 1;
        end
      end else if (m_cmd == 0) begin
        if (done) begin
          if (wr_req && (!rd_req || m_streak >= STARVE_MAX)) begin
            m_cmd = 2; m_addr = wr_addr; m_wdata = wr_data;
          end else if (rd_req) begin
            m_cmd = 1; m_addr = rd_addr;
          end
        end
      end else if (racc) begin
        m_cmd = 0; m_lat = RD_LAT; m_rdcnt = (m_rdcnt + 1) % 65536;
      end else if (wacc) begin
        mem_arr[m_addr[2:0]] = m_wdata;
        m_cmd = 0; m_wrcnt = (m_wrcnt + 1) % 65536;
      end
      m_streak = ns;
    end
  end

  task automatic do_reset();
    @(negedge sdram_clk);
    iRST_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mem_waitrequest = 1'b0; done = 1'b1;
    @(negedge sdram_clk);
    @(negedge sdram_clk);
    iRST_n = 1'b1;
  endtask

  task automatic test_reset();
    iRST_n = 1'b0; done = 1'b1; rd_req = 1'b1; wr_req = 1'b1; mem_waitrequest = 1'b0;
    rd_addr = 25'h1F0F0; wr_addr = 25'h0ABCD; wr_data = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge sdram_clk); #1;
      checks++;
      if ({mem_read, mem_write, rd_ack, wr_ack, rd_valid} !== 5'b0) begin
        failures++;
        $display("FAIL reset_ctrl got=%b exp=00000", {mem_read, mem_write, rd_ack, wr_ack, rd_valid});
      end
      checks++;
      if ({mem_addr, mem_wdata, rd_data} !== '0) begin
        failures++;
        $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0", mem_addr, mem_wdata, rd_data);
      end
      checks++;
      if ({rd_grant_cnt, wr_grant_cnt} !== 32'd0) begin
        failures++;
        $display("FAIL reset_cnt got=%h/%h exp=0/0", rd_grant_cnt, wr_grant_cnt);
      end
    end
    rd_req = 1'b0; wr_req = 1'b0; iRST_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge sdram_clk);
    rd_req = 1'b1; rd_addr = 25'h00010; mem_waitrequest = 1'b0; done = 1'b1;
    @(negedge sdram_clk); #1;
    checks++;
    if ({mem_read, rd_ack, mem_write} !== 3'b110 || mem_addr !== 25'h00010) begin
      failures++;
      $display("FAIL single_issue rd/ack/wr=%b addr=%h exp=110 addr=00010", {mem_read, rd_ack, mem_write}, mem_addr);
    end
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge sdram_clk);
      rd_req = 1'b0;
      mem_readdata = (k == RD_LAT) ? 16'h00B9 : 16'h1234;
      #1;
      checks++;
      if ({mem_read, rd_valid} !== 2'b00) begin
        failures++;
        $display("FAIL single_wait k=%0d rd/valid=%b exp=00", k, {mem_read, rd_valid});
      end
    end
    @(negedge sdram_clk); mem_readdata = 16'h0BAD; #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h00B9) begin
      failures++;
      $display("FAIL single_valid valid=%b data=%h exp=1 00b9", rd_valid, rd_data);
    end
    @(negedge sdram_clk); #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h00B9) begin
      failures++;
      $display("FAIL single_hold valid=%b data=%h exp=0 00b9", rd_valid, rd_data);
    end
  endtask

  task automatic test_wait_read();
    @(negedge sdram_clk);
    rd_req = 1'b1; rd_addr = 25'h00123; mem_waitrequest = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge sdram_clk);
      mem_waitrequest = (k < 4);
      #1;
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== 25'h00123 || rd_ack !== (k == 4)) begin
        failures++;
        $display("FAIL wait_hold k=%0d read=%b addr=%h ack=%b exp=1 00123 %b", k, mem_read, mem_addr, rd_ack, (k == 4));
      end
    end
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge sdram_clk);
      rd_req = 1'b0; mem_waitrequest = 1'b0;
      mem_readdata = (k == RD_LAT) ? 16'h5A5A : 16'h4321;
      #1;
      checks++;
      if ({mem_read, rd_valid, rd_ack} !== 3'b000) begin
        failures++;
        $display("FAIL wait_lat k=%0d read/valid/ack=%b exp=000", k, {mem_read, rd_valid, rd_ack});
      end
    end
    @(negedge sdram_clk); mem_readdata = 16'h0BAD; #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A) begin
      failures++;
      $display("FAIL wait_valid valid=%b data=%h exp=1 5a5a", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge sdram_clk);
    rd_req = 1'b1; rd_addr = 25'h01ABC; mem_readdata = 16'hDEAD;
    @(negedge sdram_clk); #1;
    checks++;
    if (mem_read !== 1'b1 || rd_ack !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_issue read=%b ack=%b exp=1 1", mem_read, rd_ack);
    end
    @(negedge sdram_clk);
    rd_req = 1'b0; iRST_n = 1'b0;
    @(negedge sdram_clk);
    iRST_n = 1'b1; #1;
    checks++;
    if ({mem_read, mem_write, rd_valid, rd_ack, wr_ack} !== 5'b0 || {mem_addr, mem_wdata, rd_data} !== '0) begin
      failures++;
      $display("FAIL rstmid_clear ctrl=%b addr=%h wdata=%h rdata=%h exp=0", {mem_read, mem_write, rd_valid, rd_ack, wr_ack}, mem_addr, mem_wdata, rd_data);
    end
    for (int k = 0; k < RD_LAT + 2; k++) begin
      @(negedge sdram_clk); #1;
      checks++;
      if (rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_novalid k=%0d valid=%b exp=0", k, rd_valid);
      end
    end
    @(negedge sdram_clk);
    wr_req = 1'b1; wr_addr = 25'h00055; wr_data = 16'hA5A5;
    @(negedge sdram_clk); #1;
    checks++;
    if ({mem_write, wr_ack, mem_read} !== 3'b110 || mem_addr !== 25'h00055 || mem_wdata !== 16'hA5A5) begin
      failures++;
      $display("FAIL rstmid_write wr/ack/rd=%b addr=%h wdata=%h exp=110 00055 a5a5", {mem_write, wr_ack, mem_read}, mem_addr, mem_wdata);
    end
    @(negedge sdram_clk); wr_req = 1'b0; #1;
    checks++;
    if ({mem_write, wr_ack} !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_wrdone wr/ack=%b exp=00", {mem_write, wr_ack});
    end
  endtask

  task automatic test_starvation();
    int rd_run = 0;
    int nwr = 0;
    do_reset();
    for (int c = 0; c < 400 && nwr < 3; c++) begin
      @(negedge sdram_clk);
      rd_req = 1'b1; wr_req = 1'b1; done = 1'b1; mem_waitrequest = 1'b0;
      mem_readdata = 16'($urandom);
      if (c % 5 == 0) begin
        rd_addr = (mem_read) ? rd_addr : 25'($urandom);
      end
      #1;
      checks++;
      if (mem_read && mem_write) begin
        failures++;
        $display("FAIL starve_excl read=%b write=%b exp=not both", mem_read, mem_write);
      end
      if (rd_ack) begin
        rd_run++;
        checks++;
        if (rd_run > STARVE_MAX) begin
          failures++;
          $display("FAIL starve_rdrun run=%0d exp<=%0d", rd_run, STARVE_MAX);
        end
      end
      if (wr_ack) begin
        checks++;
        if (rd_run !== STARVE_MAX) begin
          failures++;
          $display("FAIL starve_pattern reads_before_write=%0d exp=%0d", rd_run, STARVE_MAX);
        end
        rd_run = 0;
        nwr++;
        wr_addr = 25'($urandom); wr_data = 16'($urandom);
      end
    end
    checks++;
    if (nwr !== 3) begin
      failures++;
      $display("FAIL starve_timeout writes=%0d exp=3", nwr);
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (RD_LAT + 3) @(negedge sdram_clk);
  endtask

  task automatic test_done_low();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge sdram_clk);
      done = 1'b0; rd_req = 1'b1; wr_req = 1'b1; rd_addr = 25'h00777; mem_waitrequest = 1'b0;
      #1;
      checks++;
      if ({mem_read, mem_write, rd_ack, wr_ack} !== 4'b0) begin
        failures++;
        $display("FAIL doneLow k=%0d rd/wr/rack/wack=%b exp=0000", k, {mem_read, mem_write, rd_ack, wr_ack});
      end
    end
    @(negedge sdram_clk); done = 1'b1;
    @(negedge sdram_clk); #1;
    checks++;
    if ({mem_read, mem_write, rd_ack} !== 3'b101 || mem_addr !== 25'h00777) begin
      failures++;
      $display("FAIL doneRise rd/wr/ack=%b addr=%h exp=101 00777", {mem_read, mem_write, rd_ack}, mem_addr);
    end
    @(negedge sdram_clk); rd_req = 1'b0; wr_req = 1'b0;
    repeat (RD_LAT + 2) @(negedge sdram_clk);
  endtask

  task automatic test_random();
    bit rack_e, wack_e;
    bit rackd = 0, wackd = 0;
    for (int i = 0; i < 8; i++) mem_arr[i] = 16'(i * 4099 + 17);
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge sdram_clk);
      if (!rd_req || rackd) begin
        rd_req = ($urandom_range(0, 99) < 60);
        rd_addr = 25'($urandom);
      end
      if (!wr_req || wackd) begin
        wr_req = ($urandom_range(0, 99) < 40);
        wr_addr = 25'($urandom);
        wr_data = 16'($urandom);
      end
      done = ($urandom_range(0, 19) != 0);
      mem_waitrequest = ($urandom_range(0, 99) < 30);
      mem_readdata = (m_lat == 1) ? mem_arr[m_addr[2:0]] : 16'($urandom);
      #1;
      rack_e = (m_cmd == 1) && !mem_waitrequest;
      wack_e = (m_cmd == 2) && !mem_waitrequest;
      checks++;
      if ({mem_read, mem_write} !== {m_cmd == 1, m_cmd == 2}) begin
        failures++;
        $display("FAIL rnd_strobe c=%0d got=%b exp=%b", c, {mem_read, mem_write}, {m_cmd == 1, m_cmd == 2});
      end
      checks++;
      if ({rd_ack, wr_ack} !== {rack_e, wack_e}) begin
        failures++;
        $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, {rd_ack, wr_ack}, {rack_e, wack_e});
      end
      checks++;
      if (mem_addr !== m_addr || mem_wdata !== m_wdata) begin
        failures++;
        $display("FAIL rnd_cmd c=%0d addr=%h wdata=%h exp=%h %h", c, mem_addr, mem_wdata, m_addr, m_wdata);
      end
      checks++;
      if (rd_valid !== m_rv || rd_data !== m_rdata) begin
        failures++;
        $display("FAIL rnd_rdata c=%0d valid=%b data=%h exp=%b %h", c, rd_valid, rd_data, m_rv, m_rdata);
      end
      rackd = rack_e;
      wackd = wack_e;
    end
    checks++;
`ifdef ARB_STATS_EN
    if (rd_grant_cnt !== 16'(m_rdcnt) || wr_grant_cnt !== 16'(m_wrcnt)) begin
      failures++;
      $display("FAIL rnd_stats got=%0d/%0d exp=%0d/%0d", rd_grant_cnt, wr_grant_cnt, m_rdcnt, m_wrcnt);
    end
`else
    if (rd_grant_cnt !== 16'd0 || wr_grant_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rnd_stats got=%0d/%0d exp=0/0", rd_grant_cnt, wr_grant_cnt);
    end
`endif
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic test_stats();
    bit got;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge sdram_clk);
      done = 1'b1;
      if (i < 5) begin rd_req = 1'b1; rd_addr = 25'(i); end
      else begin wr_req = 1'b1; wr_addr = 25'(i); wr_data = 16'(i * 3); end
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge sdram_clk);
        mem_waitrequest = ($urandom_range(0, 1) == 1);
        #1;
        got = (i < 5) ? rd_ack : wr_ack;
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL stats_timeout txn=%0d ack=0 exp=1", i);
      end
      @(negedge sdram_clk);
      rd_req = 1'b0; wr_req = 1'b0; mem_waitrequest = 1'b0;
      repeat (RD_LAT + 2) @(negedge sdram_clk);
    end
    #1;
    checks++;
`ifdef ARB_STATS_EN
    if (rd_grant_cnt !== 16'd5 || wr_grant_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stats_count got=%0d/%0d exp=5/3", rd_grant_cnt, wr_grant_cnt);
    end
`else
    if (rd_grant_cnt !== 16'd0 || wr_grant_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stats_count got=%0d/%0d exp=0/0", rd_grant_cnt, wr_grant_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_wait_read();
    test_reset_mid();
    test_starvation();
    test_done_low();
    test_random();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters: the display read path (port R, which fetches palette indices for the VGA scan) and a frame-buffer writer (port W, pattern or button-driven updates).
- Serialises commands and enforces read-data latency. Read has priority; a streak limit bounds write starvation.
- Sits between the requesters and the SDRAM controller, all in the sdram_clk domain.

Parameters:
- ADDR_W, 25, SDRAM word address width.
- DATA_W, 16, SDRAM data width.
- RD_LAT, 2, clock edges from read acceptance to valid mem_readdata (range 1..7).
- STARVE_MAX, 8, maximum consecutive read grants while wr_req is pending (range 1..255).

Ports:
- sdram_clk  in  1  clock; all logic on its rising edge.
- iRST_n  in  1  synchronous, active-low reset.
- done  in  1  SDRAM init complete; no command is issued while low.
- rd_req  in  1  port R request; held with rd_addr stable until rd_ack.
- rd_addr  in  ADDR_W  port R address.
- rd_ack  out  1  combinational; read accepted this cycle.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  DATA_W  returned read word; holds until the next rd_valid.
- wr_req  in  1  port W request; held with wr_addr and wr_data stable until wr_ack.
- wr_addr  in  ADDR_W  port W address.
- wr_data  in  DATA_W  port W data.
- wr_ack  out  1  combinational; write accepted this cycle.
- mem_read  out  1  controller read strobe.
- mem_write  out  1  controller write strobe.
- mem_addr  out  ADDR_W  controller address (registered).
- mem_wdata  out  DATA_W  controller write data (registered).
- mem_readdata  in  DATA_W  controller read data.
- mem_waitrequest  in  1  controller stall; a command is accepted on an edge where its strobe is 1 and waitrequest is 0.
- rd_grant_cnt  out  16  read acceptances (ARB_STATS_EN).
- wr_grant_cnt  out  16  write acceptances (ARB_STATS_EN).

Behaviour:
- Reset (iRST_n=0 at an edge) forces:
  - state to IDLE; mem_read, mem_write, rd_valid all 0.
  - mem_addr, mem_wdata, rd_data all 0; streak counter and latency counter 0.
  - Takes effect mid-operation too. Any in-flight read is discarded and no rd_valid is generated for it.
- FSM states:
  - IDLE: no strobe.
  - RD_ISSUE: mem_read=1.
  - RD_WAIT: latency countdown.
  - WR_ISSUE: mem_write=1.
- IDLE, with done=1:
  - Write first if wr_req && (!rd_req || streak>=STARVE_MAX): go to WR_ISSUE.
  - Otherwise, if rd_req: go to RD_ISSUE.
  - Otherwise stay in IDLE.
  - On the grant edge, latch mem_addr (and mem_wdata for writes) from the granted port.
- IDLE, with done=0: remain in IDLE regardless of requests.
- RD_ISSUE:
  - rd_ack = ~mem_waitrequest.
  - On the acceptance edge: mem_read goes 0, latency counter loads RD_LAT, go to RD_WAIT.
  - Otherwise hold mem_read and mem_addr.
- RD_WAIT:
  - Counter decrements each edge.
  - On the edge where the counter is 1, capture rd_data<=mem_readdata and set rd_valid=1 for the next cycle, then go to IDLE.
  - Read-to-rd_valid latency = RD_LAT edges after acceptance.
  - Only one read is outstanding at a time; no command is issued in RD_WAIT.
- WR_ISSUE:
  - wr_ack = ~mem_waitrequest.
  - On the acceptance edge: mem_write goes 0, go to IDLE.
- Ack timing: acks are combinational, so a requester may present its next request in the cycle after ack. The IDLE cycle after a completed command re-arbitrates, which gives a minimum spacing of 2 cycles per write and RD_LAT+2 per read.
- Streak counter (8-bit, saturating at 255):
  - Increments on each read acceptance while wr_req=1.
  - Clears on write acceptance, or on any edge with wr_req=0.
- Strobe exclusivity: mem_read and mem_write are never both 1. Strobes never assert while done=0.
- done falling mid-command: the current command completes normally; no new grant is made.
- Simultaneous rd_req and wr_req with streak<STARVE_MAX: read wins.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: rd_grant_cnt and wr_grant_cnt count acceptances. They are 16-bit, wrap 0xFFFF→0, and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is synthesised.
- Arbitration behaviour is identical either way.

Test Plan:
- done=1, single rd_req at addr 0x00010, waitrequest=0, mem_readdata=0xB9 at the RD_LAT edge:
  - Required: mem_read high 1 cycle, rd_ack in the same cycle, rd_valid exactly 2 edges later, rd_data=0xB9.
- Read with mem_waitrequest=1 for 3 cycles:
  - Required: mem_read and mem_addr held 4 cycles, single rd_ack on the 4th, rd_valid RD_LAT edges after that.
- rd_req and wr_req both held continuously:
  - Required: 8 read grants, then 1 write grant, repeating.
  - wr_ack observed after every 8th rd_ack; never two strobes at once.
- done=0 with both requests high for 20 cycles:
  - Required: no strobe and no ack.
  - Raising done gives a read grant on the next edge.
- iRST_n=0 during RD_WAIT:
  - Required: no rd_valid, all outputs 0 on the next cycle.
  - After release, IDLE; a fresh write completes normally.
- With ARB_STATS_EN, 5 reads and 3 writes:
  - Required: rd_grant_cnt=5 and wr_grant_cnt=3; both are 0 when the macro is undefined.
